piece_board_commit: RTL and testbench
=====================================

// Module: piece_board_commit
// PURPOSE
//  Consumer end of the piece-spawn cell stream. Receives 4 (pos_i,pos_j) cells, one per cycle,
//  plus the piece type, then checks each cell against the board (bounds + occupancy).
//  If every cell is free, it writes the piece into the board RAM; otherwise it flags a spawn
//  collision (game over). Sits between the piece generator and the board storage.
// PARAMETERS
//  ROWS   20  board rows; valid pos_i = 0..ROWS-1
//  COLS   10  board columns; valid pos_j = 0..COLS-1
//  CELLS   4  cells per piece; fixed at 4 in this revision
// PORTS
//  clk          in   1  system clock, rising edge
//  reset        in   1  asynchronous, active-low reset
//  enable       in   1  operation window; low returns the block to IDLE (abort)
//  cell_valid   in   1  cell_i/cell_j/piece_type valid this cycle
//  cell_i       in   5  cell row
//  cell_j       in   5  cell column
//  piece_type   in   3  piece code (`Q/S/Z/T/L/J/I_PIECE); sampled with the first cell
//  rd_i, rd_j   out  5  board read address
//  rd_en        out  1  board read strobe
//  rd_data      in   3  board cell contents, valid 1 cycle after rd_en; `NULL_PIECE = empty
//  wr_en        out  1  board write strobe
//  wr_i, wr_j   out  5  board write address
//  wr_data      out  3  value written (latched piece_type)
//  busy         out  1  high outside IDLE
//  done         out  1  1-cycle pulse: piece processed (committed or collided)
//  collision    out  1  result of the last piece; held until the next piece's first cell
// BEHAVIOUR
//  Reset: state=IDLE; idx=0; all outputs 0; addresses 0; wr_data=`NULL_PIECE; cell buffer cleared.
//  FSM states: IDLE -> COLLECT -> CHECK -> COMMIT -> FIN -> IDLE (CHECK -> FIN on a hit).
//  IDLE: on enable && cell_valid, store cell 0, latch piece_type, clear collision, idx=1 -> COLLECT.
//  COLLECT: each cell_valid stores buf[idx] and increments idx. Gaps without cell_valid are allowed
//   (the state holds). When the 4th cell is stored -> CHECK.
//  CHECK: cycles k=0..3 issue rd_en with rd_i/rd_j = buf[k]. Response k is sampled at k+1.
//   hit |= (rd_data != `NULL_PIECE). A cell with i>=ROWS or j>=COLS sets hit directly; no read is
//   issued for it (rd_en=0 that cycle). Exit is evaluated at cycle 4: hit -> FIN, else -> COMMIT.
//  COMMIT: cycles k=0..3 assert wr_en with buf[k] and wr_data = latched type -> FIN.
//  FIN: done=1 for exactly 1 cycle; collision=hit -> IDLE.
//  Latency (no gaps): last cell to done = 10 cycles on commit, 6 cycles on collision.
//  cell_valid in CHECK/COMMIT/FIN is ignored and never buffered.
//  Abort: enable=0 in any state -> IDLE next cycle. No done is issued, and no further rd_en/wr_en
//   occur. Writes already made are not undone. collision keeps its previous value.
//  rd_en and wr_en are never high in the same cycle. piece_type changes after cell 0 are ignored.
//  Arithmetic: idx and step counters are 3-bit and saturate at 4. Bounds checks are unsigned
//   5-bit compares.
// CONFIGURATION
//  PIECE_COMMIT_CNT_EN: when defined, adds output commit_cnt[15:0]. It resets to 0, increments on
//   each done with collision=0, and saturates at 16'hFFFF. When undefined, the port and counter
//   are absent and all other behaviour is identical.
// TESTING
//  1. Empty board, Q piece cells (0,4)(0,5)(1,4)(1,5) back-to-back -> 4 reads, then wr_en at
//     those 4 addresses with wr_data=`Q_PIECE; done 10 cycles after the last cell; collision=0.
//  2. Board (1,5)=`T_PIECE, I piece (1,3)..(1,6) -> no wr_en; done; collision=1.
//  3. Cell (1,10) with COLS=10 -> no rd_en for that cell; collision=1; no writes.
//  4. Cells spaced with 2 idle cycles between them -> same writes as test 1; done 10 cycles after
//     the 4th cell.
//  5. Drop enable during COMMIT after 2 writes -> exactly 2 wr_en, IDLE next cycle, no done; the
//     next piece then processes normally.
//  6. Assert reset mid-CHECK -> all outputs 0 immediately. With PIECE_COMMIT_CNT_EN, 3 good pieces
//     -> commit_cnt=3.

Source files
------------

// File: rtl/piece_board_commit_if.sv
// Cell-stream and board-RAM bus for piece_board_commit.
// Also holds the piece codes shared by the commit block and its environment.
// master: piece generator + board storage side. slave: the commit block.

`ifndef PIECE_CODES_SVH
`define PIECE_CODES_SVH
`define NULL_PIECE 3'd0
`define Q_PIECE    3'd1
`define S_PIECE    3'd2
`define Z_PIECE    3'd3
`define T_PIECE    3'd4
`define L_PIECE    3'd5
`define J_PIECE    3'd6
`define I_PIECE    3'd7
`endif

interface piece_board_commit_if;
  // incoming cell stream
  logic       cell_valid;
  logic [4:0] cell_i;
  logic [4:0] cell_j;
  logic [2:0] piece_type;
  // board read port (rd_data valid one cycle after rd_en)
  logic       rd_en;
  logic [4:0] rd_i;
  logic [4:0] rd_j;
  logic [2:0] rd_data;
  // board write port
  logic       wr_en;
  logic [4:0] wr_i;
  logic [4:0] wr_j;
  logic [2:0] wr_data;

  modport master (
    output cell_valid, cell_i, cell_j, piece_type, rd_data,
    input  rd_en, rd_i, rd_j, wr_en, wr_i, wr_j, wr_data
  );

  modport slave (
    input  cell_valid, cell_i, cell_j, piece_type, rd_data,
    output rd_en, rd_i, rd_j, wr_en, wr_i, wr_j, wr_data
  );
endinterface

// File: rtl/piece_board_commit.sv
// piece_board_commit: collects the four cells of a freshly spawned piece,
// checks each against the board (bounds and occupancy) and either writes the
// piece into the board RAM or reports a spawn collision.
// Optional build macro PIECE_COMMIT_CNT_EN adds a saturating 16-bit count of
// successfully committed pieces on output commit_cnt.
//
// state   | meaning
// --------+---------------------------------------------------------------
// IDLE    | waiting for the first cell of a piece
// COLLECT | buffering cells 1..3 (gaps in cell_valid allowed)
// CHECK   | steps 0..3 read the board per cell, step 4 takes last response
// COMMIT  | steps 0..3 write the latched piece type at each cell
// FIN     | one-cycle done pulse, collision result published

module piece_board_commit #(
  parameter int ROWS  = 20,
  parameter int COLS  = 10,
  parameter int CELLS = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  piece_board_commit_if.slave   bus,
  output logic                  busy,
  output logic                  done,
  output logic                  collision
`ifdef PIECE_COMMIT_CNT_EN
  ,
  output logic [15:0]           commit_cnt
`endif
);

  localparam logic [2:0] LAST    = 3'(CELLS - 1);
  localparam logic [2:0] SAT     = 3'(CELLS);
  localparam logic [4:0] ROW_LIM = 5'(ROWS);
  localparam logic [4:0] COL_LIM = 5'(COLS);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    COLLECT = 3'd1,
    CHECK   = 3'd2,
    COMMIT  = 3'd3,
    FIN     = 3'd4
  } state_t;

  state_t     state;
  state_t     state_nxt;

  logic [2:0] idx;
  logic [2:0] step;
  logic [4:0] cell_buf_i [CELLS];
  logic [4:0] cell_buf_j [CELLS];
  logic [2:0] type_q;
  logic       hit;
  logic       rd_pend;
  logic       collision_q;

  logic [4:0] cur_i;
  logic [4:0] cur_j;
  logic       cur_oob;
  logic       step_live;
  logic       rd_hit;

  // Cell addressed by the current CHECK/COMMIT step; step 4 only collects
  // the last read response so its (wrapped) buffer entry is never used.
  assign cur_i     = cell_buf_i[step[1:0]];
  assign cur_j     = cell_buf_j[step[1:0]];
  assign cur_oob   = (cur_i >= ROW_LIM) || (cur_j >= COL_LIM);
  assign step_live = (step <= LAST);
  assign rd_hit    = rd_pend && (bus.rd_data != `NULL_PIECE);

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and board strobes; dropping enable silences every strobe at once
  always_comb begin
    state_nxt    = state;
    bus.rd_en    = 1'b0;
    bus.rd_i     = 5'd0;
    bus.rd_j     = 5'd0;
    bus.wr_en    = 1'b0;
    bus.wr_i     = 5'd0;
    bus.wr_j     = 5'd0;
    bus.wr_data  = `NULL_PIECE;
    done         = 1'b0;
    busy         = (state != IDLE);
    collision    = collision_q;

    if (!enable) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (bus.cell_valid) begin
            state_nxt = COLLECT;
          end
        end
        COLLECT: begin
          if (bus.cell_valid && (idx == LAST)) begin
            state_nxt = CHECK;
          end
        end
        CHECK: begin
          // Out-of-range cells never reach the RAM; they are flagged directly.
          if (step_live && !cur_oob) begin
            bus.rd_en = 1'b1;
            bus.rd_i  = cur_i;
            bus.rd_j  = cur_j;
          end
          if (step == SAT) begin
            state_nxt = (hit || rd_hit) ? FIN : COMMIT;
          end
        end
        COMMIT: begin
          bus.wr_en   = 1'b1;
          bus.wr_i    = cur_i;
          bus.wr_j    = cur_j;
          bus.wr_data = type_q;
          if (step == LAST) begin
            state_nxt = FIN;
          end
        end
        FIN: begin
          // Result is visible in the same cycle as done, then held by collision_q.
          done      = 1'b1;
          collision = hit;
          state_nxt = IDLE;
        end
        default: begin
          state_nxt = IDLE;
        end
      endcase
    end
  end

  // Cell buffer, step counter, hit accumulation and held collision result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx         <= 3'd0;
      step        <= 3'd0;
      type_q      <= `NULL_PIECE;
      hit         <= 1'b0;
      rd_pend     <= 1'b0;
      collision_q <= 1'b0;
      for (int k = 0; k < CELLS; k++) begin
        cell_buf_i[k] <= 5'd0;
        cell_buf_j[k] <= 5'd0;
      end
    end else begin
      rd_pend <= bus.rd_en;

      if (state != state_nxt) begin
        step <= 3'd0;
      end else if (step != SAT) begin
        step <= step + 3'd1;
      end

      if (enable) begin
        case (state)
          IDLE: begin
            if (bus.cell_valid) begin
              cell_buf_i[0] <= bus.cell_i;
              cell_buf_j[0] <= bus.cell_j;
              type_q        <= bus.piece_type;
              collision_q   <= 1'b0;
              hit           <= 1'b0;
              idx           <= 3'd1;
            end
          end
          COLLECT: begin
            if (bus.cell_valid && (idx <= LAST)) begin
              cell_buf_i[idx[1:0]] <= bus.cell_i;
              cell_buf_j[idx[1:0]] <= bus.cell_j;
              idx                  <= idx + 3'd1;
            end
          end
          CHECK: begin
            if ((step_live && cur_oob) || rd_hit) begin
              hit <= 1'b1;
            end
          end
          FIN: begin
            collision_q <= hit;
          end
          default: begin
          end
        endcase
      end
    end
  end

`ifdef PIECE_COMMIT_CNT_EN
  // Count pieces that finished without a collision, saturating at all-ones
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      commit_cnt <= 16'd0;
    end else if (enable && (state == FIN) && !hit && (commit_cnt != 16'hFFFF)) begin
      commit_cnt <= commit_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_piece_board_commit.sv
// Self-checking bench for piece_board_commit: a board RAM model answers reads,
// and expected reads, writes and done results are queued when each piece is
// driven and compared as the DUT produces them.

module tb_piece_board_commit;

  logic clk = 1'b0;
  logic reset;
  logic enable;
  logic busy;
  logic done;
  logic collision;
`ifdef PIECE_COMMIT_CNT_EN
  logic [15:0] commit_cnt;
`endif

  piece_board_commit_if bus ();

  piece_board_commit #(.ROWS(20), .COLS(10), .CELLS(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .bus       (bus),
    .busy      (busy),
    .done      (done),
    .collision (collision)
`ifdef PIECE_COMMIT_CNT_EN
    ,
    .commit_cnt(commit_cnt)
`endif
  );

  initial forever #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // board RAM model
  logic [2:0] board [0:19][0:9];
  logic       clear_en = 1'b0;
  logic       preset_en = 1'b0;
  logic [4:0] preset_i = 5'd0;
  logic [4:0] preset_j = 5'd0;
  logic [2:0] preset_v = 3'd0;

  always @(posedge clk) begin
    if (bus.rd_en)
      bus.rd_data <= (bus.rd_i < 5'd20 && bus.rd_j < 5'd10) ? board[bus.rd_i][bus.rd_j] : `NULL_PIECE;
    if (clear_en) begin
      for (int r = 0; r < 20; r++)
        for (int c = 0; c < 10; c++)
          board[r][c] <= `NULL_PIECE;
    end else if (preset_en) begin
      board[preset_i][preset_j] <= preset_v;
    end else if (bus.wr_en && bus.wr_i < 5'd20 && bus.wr_j < 5'd10) begin
      board[bus.wr_i][bus.wr_j] <= bus.wr_data;
    end
  end

  // scoreboard
  logic [9:0]  exp_rd [$];
  logic [12:0] exp_wr [$];
  bit          exp_coll [$];
  int          exp_lat [$];
  int          last_cyc = 0;
  bit          exp_last = 1'b0;

  always @(negedge clk) begin
    if (reset) begin
      if (bus.rd_en) begin
        check("rd_wr_excl", {31'd0, bus.wr_en}, 32'd0);
        if (exp_rd.size() == 0) check("rd_extra", {31'd0, bus.rd_en}, 32'd0);
        else check("rd_addr", {22'd0, bus.rd_i, bus.rd_j}, {22'd0, exp_rd.pop_front()});
      end
      if (bus.wr_en) begin
        if (exp_wr.size() == 0) check("wr_extra", {31'd0, bus.wr_en}, 32'd0);
        else check("wr_addr_data", {19'd0, bus.wr_i, bus.wr_j, bus.wr_data}, {19'd0, exp_wr.pop_front()});
      end
      if (done) begin
        if (exp_coll.size() == 0) begin
          check("done_extra", {31'd0, done}, 32'd0);
        end else begin
          check("done_coll", {31'd0, collision}, {31'd0, exp_coll.pop_front()});
          check("done_lat", cyc - last_cyc, exp_lat.pop_front());
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_board();
    clear_en = 1'b1;
    tick();
    clear_en = 1'b0;
  endtask

  task automatic preset(input logic [4:0] i, input logic [4:0] j, input logic [2:0] v);
    preset_i = i; preset_j = j; preset_v = v; preset_en = 1'b1;
    tick();
    preset_en = 1'b0;
  endtask

  // Predict reads, writes and result from the current board contents.
  task automatic model_piece(input logic [3:0][4:0] ci, input logic [3:0][4:0] cj,
                             input logic [2:0] pt, input int nwr, input bit has_done);
    bit h = 1'b0;
    for (int k = 0; k < 4; k++) begin
      if (ci[k] >= 5'd20 || cj[k] >= 5'd10) h = 1'b1;
      else begin
        exp_rd.push_back({ci[k], cj[k]});
        if (board[ci[k]][cj[k]] != `NULL_PIECE) h = 1'b1;
      end
    end
    if (!h)
      for (int k = 0; k < nwr; k++) exp_wr.push_back({ci[k], cj[k], pt});
    if (has_done) begin
      exp_coll.push_back(h);
      exp_lat.push_back(h ? 6 : 10);
      exp_last = h;
    end
  endtask

  // Drive 4 cells; later cells carry a random piece_type that must be ignored.
  task automatic drive_cells(input logic [3:0][4:0] ci, input logic [3:0][4:0] cj,
                             input logic [2:0] pt, input int gap);
    for (int k = 0; k < 4; k++) begin
      tick();
      bus.cell_valid = 1'b1;
      bus.cell_i     = ci[k];
      bus.cell_j     = cj[k];
      bus.piece_type = (k == 0) ? pt : 3'($urandom_range(1, 7));
      if (k < 3) begin
        repeat (gap) begin
          tick();
          bus.cell_valid = 1'b0;
        end
      end
    end
    last_cyc = cyc;
  endtask

  task automatic run_piece(input logic [3:0][4:0] ci, input logic [3:0][4:0] cj,
                           input logic [2:0] pt, input int gap, input bit junk);
    int n = 0;
    model_piece(ci, cj, pt, 4, 1'b1);
    drive_cells(ci, cj, pt, gap);
    tick();
    if (junk) begin
      repeat (3) begin
        bus.cell_valid = 1'b1;
        bus.cell_i     = 5'($urandom_range(0, 19));
        bus.cell_j     = 5'($urandom_range(0, 9));
        tick();
      end
    end
    bus.cell_valid = 1'b0;
    while (busy && n < 40) begin
      tick();
      n++;
    end
    check("idle_timeout", {31'd0, busy}, 32'd0);
    check("coll_hold", {31'd0, collision}, {31'd0, exp_last});
    tick();
  endtask

  task automatic run_abort(input logic [3:0][4:0] ci, input logic [3:0][4:0] cj,
                           input logic [2:0] pt, input int nwr);
    model_piece(ci, cj, pt, nwr, 1'b0);
    drive_cells(ci, cj, pt, 0);
    tick();
    bus.cell_valid = 1'b0;
    repeat (5 + nwr) tick();
    enable = 1'b0;
    tick();
    check("abort_idle", {31'd0, busy}, 32'd0);
    check("abort_coll", {31'd0, collision}, 32'd0);
    enable = 1'b1;
    repeat (3) tick();
  endtask

  initial begin
    reset          = 1'b0;
    enable         = 1'b0;
    bus.cell_valid = 1'b0;
    bus.cell_i     = 5'd0;
    bus.cell_j     = 5'd0;
    bus.piece_type = `NULL_PIECE;
    clear_board();
    repeat (2) tick();
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_coll", {31'd0, collision}, 32'd0);
    check("rst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check("rst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("rst_addr", {12'd0, bus.rd_i, bus.rd_j, bus.wr_i, bus.wr_j}, 32'd0);
    check("rst_wr_data", {29'd0, bus.wr_data}, {29'd0, `NULL_PIECE});
    reset  = 1'b1;
    enable = 1'b1;
    tick();

    // empty board, Q piece back-to-back, junk cell_valid during CHECK
    run_piece({5'd1, 5'd1, 5'd0, 5'd0}, {5'd5, 5'd4, 5'd5, 5'd4}, `Q_PIECE, 0, 1'b1);
    // occupied cell under an I piece
    clear_board();
    preset(5'd1, 5'd5, `T_PIECE);
    run_piece({5'd1, 5'd1, 5'd1, 5'd1}, {5'd6, 5'd5, 5'd4, 5'd3}, `I_PIECE, 0, 1'b0);
    // column out of range: no read for that cell
    clear_board();
    run_piece({5'd1, 5'd1, 5'd0, 5'd0}, {5'd10, 5'd9, 5'd9, 5'd8}, `S_PIECE, 0, 1'b0);
    // row out of range
    run_piece({5'd20, 5'd19, 5'd19, 5'd18}, {5'd1, 5'd1, 5'd0, 5'd0}, `J_PIECE, 0, 1'b0);
    // bottom-right corner is in range
    run_piece({5'd19, 5'd19, 5'd19, 5'd18}, {5'd7, 5'd8, 5'd9, 5'd9}, `L_PIECE, 0, 1'b0);
    // gaps of 2 idle cycles between cells
    clear_board();
    run_piece({5'd1, 5'd1, 5'd0, 5'd0}, {5'd5, 5'd4, 5'd5, 5'd4}, `Q_PIECE, 2, 1'b0);
    // abort after 2 writes, then normal pieces (second one hits the partial write)
    clear_board();
    run_abort({5'd1, 5'd1, 5'd0, 5'd0}, {5'd5, 5'd4, 5'd5, 5'd4}, `Q_PIECE, 2);
    run_piece({5'd6, 5'd6, 5'd5, 5'd5}, {5'd2, 5'd1, 5'd1, 5'd0}, `Z_PIECE, 0, 1'b0);
    run_piece({5'd1, 5'd0, 5'd0, 5'd0}, {5'd2, 5'd2, 5'd4, 5'd3}, `L_PIECE, 1, 1'b0);

    // reset mid-CHECK
    clear_board();
    model_piece({5'd3, 5'd3, 5'd3, 5'd3}, {5'd3, 5'd2, 5'd1, 5'd0}, `I_PIECE, 0, 1'b0);
    drive_cells({5'd3, 5'd3, 5'd3, 5'd3}, {5'd3, 5'd2, 5'd1, 5'd0}, `I_PIECE, 0);
    tick();
    bus.cell_valid = 1'b0;
    tick();
    reset = 1'b0;
    #1;
    check("midrst_busy", {31'd0, busy}, 32'd0);
    check("midrst_rd_en", {31'd0, bus.rd_en}, 32'd0);
    check("midrst_wr_en", {31'd0, bus.wr_en}, 32'd0);
    check("midrst_done_coll", {30'd0, done, collision}, 32'd0);
    exp_rd.delete();
    exp_wr.delete();
    tick();
    reset = 1'b1;
    tick();

    run_piece({5'd11, 5'd10, 5'd10, 5'd10}, {5'd1, 5'd2, 5'd1, 5'd0}, `T_PIECE, 0, 1'b0);
    run_piece({5'd14, 5'd14, 5'd13, 5'd12}, {5'd4, 5'd5, 5'd5, 5'd5}, `J_PIECE, 0, 1'b0);
    run_piece({5'd15, 5'd15, 5'd15, 5'd15}, {5'd3, 5'd2, 5'd1, 5'd0}, `I_PIECE, 0, 1'b0);
`ifdef PIECE_COMMIT_CNT_EN
    check("commit_cnt", {16'd0, commit_cnt}, 32'd3);
`endif

    repeat (5) tick();
    check("rd_left", exp_rd.size(), 0);
    check("wr_left", exp_wr.size(), 0);
    check("done_left", exp_coll.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
